// File: rtl/nibbler_io_pkg.sv
// Shared defaults and types for the Nibbler output-port bank.
package nibbler_io_pkg;

  localparam int unsigned DefWidth    = 4;
  localparam int unsigned DefChannels = 4;
  localparam int unsigned DefDepth    = 4;

  // Select bus stays at least one bit wide even for a single channel.
  function automatic int unsigned sel_width(input int unsigned channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  typedef struct packed {
    logic valid;
    logic full;
    logic ovf;
  } chan_status_t;

endpackage

// File: rtl/out_chan_fifo.sv
// One output channel: circular FIFO with count, pointers and a sticky overflow flag.
module out_chan_fifo
  import nibbler_io_pkg::*;
#(
  parameter int unsigned Width = DefWidth,
  parameter int unsigned Depth = DefDepth
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [Width-1:0] data,
  input  logic             ack,
  input  logic             clr_ovf,
  output logic [Width-1:0] head,
  output chan_status_t     status
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             ovf_q;
  logic             is_full, is_valid, pop, push_ok, ovf_set;

  always_comb begin
    is_full  = (count_q == CntW'(Depth));
    is_valid = (count_q != '0);
    pop      = ack && is_valid;
    // A pop frees the slot in the same cycle, so a full channel still accepts.
    push_ok  = push && (!is_full || pop);
    ovf_set  = push && is_full && !pop;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({push_ok, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
      if (ovf_set)      ovf_q <= 1'b1;
      else if (clr_ovf) ovf_q <= 1'b0;
    end
  end

  // Storage needs no reset: head is gated by valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data;
  end

  always_comb begin
    head         = is_valid ? mem_q[rd_ptr_q] : '0;
    status.valid = is_valid;
    status.full  = is_full;
    status.ovf   = ovf_q;
  end

endmodule

// File: rtl/out_port_bank.sv
// Bank of independent FIFO-backed output ports written from the Nibbler data bus.
module out_port_bank
  import nibbler_io_pkg::*;
#(
  parameter int unsigned WIDTH    = DefWidth,
  parameter int unsigned CHANNELS = DefChannels,
  parameter int unsigned DEPTH    = DefDepth
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                enable,
  input  logic [WIDTH-1:0]                    D,
  input  logic [sel_width(CHANNELS)-1:0]      sel,
  input  logic [CHANNELS-1:0]                 ack,
  input  logic                                clr_ovf,
  output logic [CHANNELS*WIDTH-1:0]           Q,
  output logic [CHANNELS-1:0]                 valid,
  output logic [CHANNELS-1:0]                 full,
  output logic [CHANNELS-1:0]                 ovf
);

  localparam int unsigned SelW = sel_width(CHANNELS);

  chan_status_t st [CHANNELS];

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    logic push_c;

    // Out-of-range selects match no channel and are dropped silently.
    assign push_c = enable && (sel == SelW'(c));

    out_chan_fifo #(
      .Width (WIDTH),
      .Depth (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (push_c),
      .data    (D),
      .ack     (ack[c]),
      .clr_ovf (clr_ovf),
      .head    (Q[c*WIDTH +: WIDTH]),
      .status  (st[c])
    );

    assign valid[c] = st[c].valid;
    assign full[c]  = st[c].full;
    assign ovf[c]   = st[c].ovf;
  end

endmodule
